// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-stage defines: ALU op codes, FSM states, bus sizes.
// Helper functions classify ops and build store lanes.
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP,
                      EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load_op(op) |
           (op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP});
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    logic [1:0] s;
    s = SIZE_W;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: s = SIZE_B;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = SIZE_H;
      default: s = SIZE_W;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(
    input logic [7:0]  op,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d;
    case (op)
      EXE_SB_OP: w = {4{d[7:0]}};
      EXE_SH_OP: w = {2{d[15:0]}};
      default:   w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane select and sign/zero extension (combinational).
// Ports: op, addr_lo[1:0], raw word in; extended value out.
module load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    unique case (addr_lo)
      2'd0: b = raw[7:0];
      2'd1: b = raw[15:8];
      2'd2: b = raw[23:16];
      2'd3: b = raw[31:24];
    endcase
    h = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (op)
      EXE_LB_OP:  value = {{24{b[7]}}, b};
      EXE_LBU_OP: value = {24'd0, b};
      EXE_LH_OP:  value = {{16{h[15]}}, h};
      EXE_LHU_OP: value = {16'd0, h};
      default:    value = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: drives the SRAM-like data bus with one
// outstanding access, aligns load data and stalls F..M while busy.
// Ports: pipeline inputs (inst_valid, alucontrol, addr, store_data,
// addr_error, exception_flush, stall_next), data_* bus, load_result,
// result_valid, mem_stall.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter bit ALIGN_ADDR = 1'b0
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [7:0]  alucontrol,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        addr_error,
  input  logic        exception_flush,
  input  logic        stall_next,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] load_result,
  output logic        result_valid,
  output logic        mem_stall
);

  mem_state_t  state;
  logic        discard;
  logic [31:0] held;

  logic        mem_op;
  logic        ld_op;
  logic        start;
  logic        req;
  logic        fin;
  logic        give;
  logic [1:0]  size;
  logic [31:0] aligned;
  logic [31:0] bus_addr;

  assign mem_op = is_mem_op(alucontrol);
  assign ld_op  = is_load_op(alucontrol);
  assign size   = op_size(alucontrol);

  // rst gate keeps every output low while reset is held
  assign start = ~rst & inst_valid & mem_op & ~addr_error &
                 ~exception_flush & (state == MEM_IDLE);
  assign req   = start | (state == MEM_REQ);
  // data returned for a live (not discarded) access
  assign fin   = (state == MEM_WAIT) & data_data_ok & ~discard;
  assign give  = fin & ~exception_flush & ~stall_next;

  load_align u_align (
    .op      (alucontrol),
    .addr_lo (addr[1:0]),
    .raw     (data_rdata),
    .value   (aligned)
  );

  always_comb begin
    bus_addr = addr;
    if (ALIGN_ADDR && size == SIZE_W) bus_addr[1:0] = 2'b00;
    else if (ALIGN_ADDR && size == SIZE_H) bus_addr[0] = 1'b0;
  end

  assign data_req   = req;
  assign data_wr    = req & ~ld_op;
  assign data_size  = req ? size : 2'd0;
  assign data_addr  = req ? bus_addr : 32'd0;
  assign data_wdata = req ? store_lanes(alucontrol, store_data) : 32'd0;

  assign result_valid = give |
                        ((state == MEM_DONE) & ~exception_flush);

  always_comb begin
    load_result = 32'd0;
    if (give) load_result = ld_op ? aligned : 32'd0;
    else if (state == MEM_DONE && !exception_flush) load_result = held;
  end

  assign mem_stall = start | (state == MEM_REQ) |
                     ((state == MEM_WAIT) & ~fin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MEM_IDLE;
      discard <= 1'b0;
      held    <= 32'd0;
    end else begin
      unique case (state)
        MEM_IDLE: begin
          if (start) state <= data_addr_ok ? MEM_WAIT : MEM_REQ;
        end
        MEM_REQ: begin
          if (exception_flush) discard <= 1'b1;
          if (data_addr_ok) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (data_data_ok) begin
            discard <= 1'b0;
            if (discard | exception_flush | ~stall_next) begin
              state <= MEM_IDLE;
            end else begin
              state <= MEM_DONE;
              held  <= ld_op ? aligned : 32'd0;
            end
          end else if (exception_flush) begin
            discard <= 1'b1;
          end
        end
        MEM_DONE: begin
          if (exception_flush | ~stall_next) state <= MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level model
// compared every cycle plus hand-computed literal expectations.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [7:0]  op = 8'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] sd = 32'd0;
  logic        aerr = 1'b0;
  logic        fl = 1'b0;
  logic        sn = 1'b0;
  logic        aok = 1'b0;
  logic        dok = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] load_result;
  logic        result_valid;
  logic        mem_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .inst_valid      (iv),
    .alucontrol      (op),
    .addr            (addr),
    .store_data      (sd),
    .addr_error      (aerr),
    .exception_flush (fl),
    .stall_next      (sn),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (aok),
    .data_data_ok    (dok),
    .data_rdata      (rdata),
    .load_result     (load_result),
    .result_valid    (result_valid),
    .mem_stall       (mem_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_load(input logic [7:0] o);
    return o == EXE_LB_OP || o == EXE_LBU_OP || o == EXE_LH_OP ||
           o == EXE_LHU_OP || o == EXE_LW_OP;
  endfunction

  function automatic bit m_store(input logic [7:0] o);
    return o == EXE_SB_OP || o == EXE_SH_OP || o == EXE_SW_OP;
  endfunction

  function automatic logic [31:0] m_size(input logic [7:0] o);
    if (o == EXE_LB_OP || o == EXE_LBU_OP || o == EXE_SB_OP) return 0;
    if (o == EXE_LH_OP || o == EXE_LHU_OP || o == EXE_SH_OP) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] o,
                                          input logic [31:0] d);
    if (o == EXE_SB_OP) return (d & 32'hFF) * 32'h01010101;
    if (o == EXE_SH_OP) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_align(input logic [7:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    if (o == EXE_LB_OP)  return (b >= 128) ? b - 256 : b;
    if (o == EXE_LBU_OP) return b;
    if (o == EXE_LH_OP)  return (h >= 32768) ? h - 65536 : h;
    if (o == EXE_LHU_OP) return h;
    return w;
  endfunction

  // transaction model: busy, address taken, doomed, parked result
  bit          mb = 0;
  bit          macc = 0;
  bit          mdoom = 0;
  bit          mpv = 0;
  logic [31:0] mpd = 32'd0;

  always @(negedge clk) begin : cmp
    bit          nw;
    bit          ereq;
    bit          edone;
    bit          erv;
    bit          estall;
    logic [31:0] elr;
    logic [31:0] ev;
    ev = m_load(op) ? m_align(op, addr, rdata) : 32'd0;
    nw = !rst && iv && (m_load(op) || m_store(op)) && !aerr && !fl &&
         !mb && !mpv;
    ereq   = nw || (!rst && mb && !macc);
    edone  = !rst && mb && macc && dok && !mdoom;
    erv    = (edone && !fl && !sn) || (!rst && mpv && !fl);
    elr    = (edone && !fl && !sn) ? ev :
             (!rst && mpv && !fl) ? mpd : 32'd0;
    estall = nw || (!rst && mb && !edone);
    chk("m_req", data_req, ereq);
    chk("m_wr", data_wr, ereq && m_store(op));
    chk("m_size", data_size, ereq ? m_size(op) : 0);
    chk("m_addr", data_addr, ereq ? addr : 0);
    chk("m_wdata", data_wdata, ereq ? m_wdata(op, sd) : 0);
    chk("m_rv", result_valid, erv);
    chk("m_lr", load_result, elr);
    chk("m_stall", mem_stall, estall);
    if (rst) begin
      mb = 0; macc = 0; mdoom = 0; mpv = 0;
    end else if (nw) begin
      mb = 1; macc = aok; mdoom = 0;
    end else if (mb && !macc) begin
      if (fl) mdoom = 1;
      if (aok) macc = 1;
    end else if (mb) begin
      if (dok) begin
        mb = 0;
        if (!mdoom && !fl && sn) begin
          mpv = 1; mpd = ev;
        end
        mdoom = 0;
      end else if (fl) begin
        mdoom = 1;
      end
    end else if (mpv) begin
      if (fl || !sn) mpv = 0;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iv = 0; aok = 0; dok = 0; fl = 0; sn = 0; aerr = 0;
  endtask

  task automatic load_chk(input string nm, input logic [7:0] o,
                          input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] expv);
    iv = 1; op = o; addr = a; aok = 1;
    @(negedge clk);
    nxt();
    aok = 0; dok = 1; rdata = w;
    @(negedge clk);
    chk(nm, load_result, expv);
    chk({nm, "_rv"}, result_valid, 1);
    nxt();
    idle_in();
  endtask

  int nreq;
  int nst;

  initial begin
    iv = 1; op = EXE_LW_OP; addr = 32'h1000;
    #2;
    chk("rst_req", data_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_rv", result_valid, 0);
    nxt(); nxt();
    rst = 0; idle_in();
    nxt();

    // LW, addr_ok immediate, data_ok after two wait cycles
    nreq = 0; nst = 0;
    iv = 1; op = EXE_LW_OP; addr = 32'h1000; aok = 1;
    @(negedge clk);
    chk("lw_size", data_size, 2);
    nreq += data_req; nst += mem_stall;
    nxt(); aok = 0;
    @(negedge clk);
    nreq += data_req; nst += mem_stall;
    nxt();
    @(negedge clk);
    nreq += data_req; nst += mem_stall;
    nxt(); dok = 1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    nreq += data_req; nst += mem_stall;
    chk("lw_rv", result_valid, 1);
    chk("lw_data", load_result, 32'hDEADBEEF);
    nxt(); idle_in();
    chk("lw_req_cycles", nreq, 1);
    chk("lw_stall_cycles", nst, 3);

    load_chk("lb", EXE_LB_OP, 32'h1003, 32'h80112233, 32'hFFFFFF80);
    load_chk("lbu", EXE_LBU_OP, 32'h1003, 32'h80112233, 32'h00000080);
    load_chk("lh", EXE_LH_OP, 32'h1002, 32'h80112233, 32'hFFFF8011);
    load_chk("lhu", EXE_LHU_OP, 32'h1000, 32'h80119233, 32'h00009233);
    load_chk("lb0", EXE_LB_OP, 32'h1000, 32'h8011227F, 32'h0000007F);

    // SB with addr_ok delayed three cycles
    iv = 1; op = EXE_SB_OP; addr = 32'h2001; sd = 32'h000000A5;
    for (int i = 0; i < 4; i++) begin
      aok = (i == 3);
      @(negedge clk);
      chk("sb_req", data_req, 1);
      chk("sb_addr", data_addr, 32'h2001);
      chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
      chk("sb_wr", data_wr, 1);
      nxt();
    end
    aok = 0;
    @(negedge clk);
    chk("sb_wait_stall", mem_stall, 1);
    chk("sb_wait_req", data_req, 0);
    nxt(); dok = 1;
    @(negedge clk);
    chk("sb_stall_rel", mem_stall, 0);
    chk("sb_rv", result_valid, 1);
    chk("sb_lr", load_result, 0);
    nxt(); idle_in();

    // SH lane replication
    iv = 1; op = EXE_SH_OP; addr = 32'h2002; sd = 32'h1234ABCD; aok = 1;
    @(negedge clk);
    chk("sh_wdata", data_wdata, 32'hABCDABCD);
    chk("sh_size", data_size, 1);
    nxt(); aok = 0; dok = 1;
    @(negedge clk);
    nxt(); idle_in();

    // flush in WAIT, newer LW held until drain
    iv = 1; op = EXE_LW_OP; addr = 32'h3000; aok = 1;
    @(negedge clk);
    nxt(); aok = 0; iv = 0; fl = 1;
    @(negedge clk);
    nxt(); fl = 0; iv = 1; op = EXE_LW_OP; addr = 32'h3004;
    @(negedge clk);
    chk("fl_hold_stall", mem_stall, 1);
    chk("fl_hold_req", data_req, 0);
    nxt(); dok = 1; rdata = 32'h11111111;
    @(negedge clk);
    chk("fl_drop_rv", result_valid, 0);
    chk("fl_drain_req", data_req, 0);
    nxt(); dok = 0; aok = 1;
    @(negedge clk);
    chk("fl_issue_req", data_req, 1);
    chk("fl_issue_addr", data_addr, 32'h3004);
    nxt(); aok = 0; dok = 1; rdata = 32'h00000055;
    @(negedge clk);
    chk("fl_new_lr", load_result, 32'h00000055);
    nxt(); idle_in();

    // data_ok while M/W stalled: parked in DONE
    iv = 1; op = EXE_LW_OP; addr = 32'h4000; aok = 1;
    @(negedge clk);
    nxt(); aok = 0; dok = 1; sn = 1; rdata = 32'h12345678;
    @(negedge clk);
    chk("dn_first_rv", result_valid, 0);
    nxt(); dok = 0; rdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("dn_rv", result_valid, 1);
      chk("dn_lr", load_result, 32'h12345678);
      chk("dn_req", data_req, 0);
      chk("dn_stall", mem_stall, 0);
      nxt();
    end
    sn = 0;
    @(negedge clk);
    chk("dn_last_lr", load_result, 32'h12345678);
    nxt(); idle_in();
    @(negedge clk);
    chk("dn_idle_rv", result_valid, 0);
    nxt();

    // no bus activity cases
    iv = 1; op = EXE_LW_OP; addr = 32'h1001; aerr = 1;
    @(negedge clk);
    chk("aerr_req", data_req, 0);
    chk("aerr_stall", mem_stall, 0);
    nxt(); idle_in();
    iv = 1; op = 8'h21; addr = 32'h1000;
    @(negedge clk);
    chk("nonmem_req", data_req, 0);
    nxt(); idle_in();
    iv = 1; op = EXE_SW_OP; addr = 32'h1000; fl = 1; aok = 1;
    @(negedge clk);
    chk("flidle_req", data_req, 0);
    chk("flidle_stall", mem_stall, 0);
    nxt(); idle_in();
    nxt();

    // reset in the middle of WAIT
    iv = 1; op = EXE_LW_OP; addr = 32'h5000; aok = 1;
    @(negedge clk);
    nxt(); aok = 0;
    rst = 1;
    #1;
    chk("ar_stall", mem_stall, 0);
    chk("ar_req", data_req, 0);
    chk("ar_rv", result_valid, 0);
    @(negedge clk);
    nxt(); rst = 0; iv = 0; dok = 1; rdata = 32'h99999999;
    @(negedge clk);
    chk("stale_rv", result_valid, 0);
    chk("stale_stall", mem_stall, 0);
    nxt(); idle_in();
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
